// File: rtl/synth_pkg.sv
// Shared defaults, FSM state encoding and output saturation for the voice scheduler.
package synth_pkg;

    localparam int unsigned NV_DEF   = 4;
    localparam int unsigned PW_DEF   = 16;
    localparam int unsigned SW_DEF   = 8;
    localparam int unsigned SUMW_DEF = SW_DEF + $clog2(NV_DEF);
    localparam int unsigned AW       = 8;

    localparam int SAT_HI = (2 ** (SW_DEF - 1)) - 1;
    localparam int SAT_LO = -(2 ** (SW_DEF - 1));

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADV  = 3'd1,
        REQ  = 3'd2,
        ACC  = 3'd3,
        OUT  = 3'd4
    } state_t;

    // Clamp the widened mix back into the signed sample range.
    function automatic logic [SW_DEF-1:0] sat(input logic signed [SUMW_DEF-1:0] s);
        if (int'(s) > SAT_HI) begin
            return SW_DEF'(SAT_HI);
        end
        if (int'(s) < SAT_LO) begin
            return SW_DEF'(SAT_LO);
        end
        return SW_DEF'(s);
    endfunction

endpackage

// File: rtl/voice_scheduler_if.sv
// Wavetable lookup (req/ack) and mixed-sample output (valid/ready) handshakes.
interface voice_scheduler_if;
    import synth_pkg::*;

    logic              wt_req;
    logic [AW-1:0]     wt_addr;
    logic              wt_ack;
    logic [SW_DEF-1:0] wt_data;
    logic              out_valid;
    logic              out_ready;
    logic [SW_DEF-1:0] out_sample;

    modport master (
        output wt_req, wt_addr, out_valid, out_sample,
        input  wt_ack, wt_data, out_ready
    );

    modport slave (
        input  wt_req, wt_addr, out_valid, out_sample,
        output wt_ack, wt_data, out_ready
    );

endinterface

// File: rtl/voice_regfile.sv
// Per-voice increment, enable and phase accumulator storage.
// One config write port and one read-modify-write port used by the ADV step.
module voice_regfile
    import synth_pkg::*;
#(
    parameter int unsigned NV = NV_DEF,
    parameter int unsigned PW = PW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_cfg_we,
    input  logic [$clog2(NV)-1:0] i_cfg_voice,
    input  logic [PW-1:0]         i_cfg_inc,
    input  logic                  i_cfg_en,
    input  logic                  i_adv,
    input  logic [$clog2(NV)-1:0] i_adv_voice,
    output logic                  o_adv_en,
    output logic [AW-1:0]         o_adv_addr,
    output logic [AW-1:0]         o_phase
);

    logic [PW-1:0] r_inc [NV];
    logic [PW-1:0] r_acc [NV];
    logic [NV-1:0] r_en;

    logic [PW-1:0] w_acc_sum;
    logic          w_cfg_zero;

    // ADV reads the pre-write inc/en; a same-voice disable zeroes the address it sees.
    assign w_acc_sum  = r_acc[i_adv_voice] + r_inc[i_adv_voice];
    assign w_cfg_zero = i_cfg_we && !i_cfg_en && (i_cfg_voice == i_adv_voice);
    assign o_adv_en   = r_en[i_adv_voice];
    assign o_adv_addr = w_cfg_zero ? '0 : w_acc_sum[PW-1 -: AW];
    assign o_phase    = r_acc[0][PW-1 -: AW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en <= '0;
            for (int unsigned i = 0; i < NV; i++) begin
                r_inc[i] <= '0;
                r_acc[i] <= '0;
            end
        end else begin
            if (i_adv) begin
                r_acc[i_adv_voice] <= r_en[i_adv_voice] ? w_acc_sum : '0;
            end
            // Config write comes last so its zeroing overrides the ADV update.
            if (i_cfg_we) begin
                r_inc[i_cfg_voice] <= i_cfg_inc;
                r_en[i_cfg_voice]  <= i_cfg_en;
                if (!i_cfg_en) begin
                    r_acc[i_cfg_voice] <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/voice_scheduler.sv
// Once per sample tick: advance every voice phase, fetch enabled voices from the shared
// wavetable port, and hand the saturated mix to the serializer.
module voice_scheduler
    import synth_pkg::*;
#(
    parameter int unsigned NV = NV_DEF,
    parameter int unsigned PW = PW_DEF,
    parameter int unsigned SW = SW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_tick,
    input  logic                  cfg_we,
    input  logic [$clog2(NV)-1:0] cfg_voice,
    input  logic [PW-1:0]         cfg_inc,
    input  logic                  cfg_en,
    voice_scheduler_if.master     bus,
    output logic [AW-1:0]         phase,
    output logic                  busy,
    output logic                  overrun,
    input  logic                  ovr_clr
);

    localparam int unsigned   VW   = $clog2(NV);
    localparam int unsigned   SUMW = SW + VW;
    localparam logic [VW-1:0] LAST = VW'(NV - 1);

    state_t                 r_state;
    logic [VW-1:0]          r_v;
    logic signed [SUMW-1:0] r_sum;
    logic signed [SW-1:0]   r_data;
    logic                   r_wt_req;
    logic [AW-1:0]          r_wt_addr;
    logic                   r_out_valid;
    logic [SW-1:0]          r_out_sample;
    logic                   r_busy;
    logic                   r_overrun;

    logic                   w_adv;
    logic                   w_adv_en;
    logic [AW-1:0]          w_adv_addr;
    logic                   w_last;
    logic signed [SUMW-1:0] w_sum_next;

    assign w_adv      = (r_state == ADV);
    assign w_last     = (r_v == LAST);
    assign w_sum_next = r_sum + SUMW'(r_data);

    voice_regfile #(.NV(NV), .PW(PW)) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .i_cfg_we    (cfg_we),
        .i_cfg_voice (cfg_voice),
        .i_cfg_inc   (cfg_inc),
        .i_cfg_en    (cfg_en),
        .i_adv       (w_adv),
        .i_adv_voice (r_v),
        .o_adv_en    (w_adv_en),
        .o_adv_addr  (w_adv_addr),
        .o_phase     (phase)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_v          <= '0;
            r_sum        <= '0;
            r_data       <= '0;
            r_wt_req     <= 1'b0;
            r_wt_addr    <= '0;
            r_out_valid  <= 1'b0;
            r_out_sample <= '0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            // A tick outside IDLE is dropped; set has priority over clear.
            if (sample_tick && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (sample_tick) begin
                        r_v     <= '0;
                        r_sum   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ADV;
                    end
                end
                ADV: begin
                    if (w_adv_en) begin
                        r_wt_req  <= 1'b1;
                        r_wt_addr <= w_adv_addr;
                        r_state   <= REQ;
                    end else if (w_last) begin
                        r_out_valid  <= 1'b1;
                        r_out_sample <= sat(r_sum);
                        r_state      <= OUT;
                    end else begin
                        r_v <= VW'(r_v + 1'b1);
                    end
                end
                REQ: begin
                    if (bus.wt_ack) begin
                        r_wt_req <= 1'b0;
                        r_data   <= bus.wt_data;
                        r_state  <= ACC;
                    end
                end
                ACC: begin
                    r_sum <= w_sum_next;
                    if (w_last) begin
                        r_out_valid  <= 1'b1;
                        r_out_sample <= sat(w_sum_next);
                        r_state      <= OUT;
                    end else begin
                        r_v     <= VW'(r_v + 1'b1);
                        r_state <= ADV;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.wt_req     = r_wt_req;
    assign bus.wt_addr    = r_wt_addr;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_sample = r_out_sample;
    assign busy           = r_busy;
    assign overrun        = r_overrun;

endmodule
